mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/arb_timeout_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encodings,
// requester IDs, the default abort timeout and the timeout counter width.
// Pure declarations; no logic, no latency, no flow control.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   localparam logic ID_I = 1'b0;
   localparam logic ID_D = 1'b1;

   localparam int TIMEOUT_CYCLES_DEF = 64;

   // Counter is one bit wider than log2 of the limit so it can hold the limit itself.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts WAIT cycles of an outstanding memory access and flags the last allowed one.
// Latency: expired is combinational from the count register (same-cycle flag).
// No backpressure; clear has priority over enable, count saturates at LIMIT-1.
//
// Ports: clk, rst (async active-low), clear, enable, expired.
module arb_timeout_counter
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = cnt_width(LIMIT);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + W'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared memory bus.
// Latency: request sampled in cycle N, strobe in N+1, done earliest in N+2.
// Requesters hold their request until done/err; stall reports a pending, uncompleted request.
//
// Ports: clk, rst (async active-low); i_addr/i_rd and d_addr/d_data_in/d_rd/d_wr from the
// requesters; mem_addr/mem_data_in/mem_rd/mem_wr to memory, mem_data_out/mem_done back;
// i_/d_ data_out, done, stall, err returned to each requester.
// Build option MEM_ARB_FAIRNESS_EN: alternate grants under contention instead of fixed
// d-over-i priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i_addr,
   input  logic        i_rd,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_data_in,
   input  logic        d_rd,
   input  logic        d_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_in,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [15:0] mem_data_out,
   input  logic        mem_done,
   output logic [15:0] i_data_out,
   output logic [15:0] d_data_out,
   output logic        i_done,
   output logic        d_done,
   output logic        i_stall,
   output logic        d_stall,
   output logic        i_err,
   output logic        d_err
);

   state_t      state;
   logic        grant_id;
   logic [15:0] hold_addr;
   logic [15:0] hold_data;
   logic        hold_wr;

   logic        d_req;
   logic        any_req;
   logic        win_d;
   logic        bad_op;
   logic        tmo_clear;
   logic        tmo_enable;
   logic        tmo_expired;

   assign d_req   = d_rd | d_wr;
   assign any_req = d_req | i_rd;

`ifdef MEM_ARB_FAIRNESS_EN
   // Holds the ID of the requester whose transaction finished last.
   logic last_id;
   assign win_d = d_req & (~i_rd | (last_id == ID_I));
`else
   assign win_d = d_req;
`endif

   // A simultaneous read+write on the data port is never sent to memory.
   assign bad_op = win_d & d_rd & d_wr;

   assign tmo_clear  = (state == ST_IDLE);
   assign tmo_enable = (state == ST_WAIT);

   arb_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   assign mem_addr    = hold_addr;
   assign mem_data_in = hold_data;

   // Gated by rst so every output reads 0 while reset is held.
   assign i_stall = rst & i_rd  & ~i_done & ~i_err;
   assign d_stall = rst & d_req & ~d_done & ~d_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         grant_id   <= ID_I;
         hold_addr  <= '0;
         hold_data  <= '0;
         hold_wr    <= 1'b0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         i_err      <= 1'b0;
         d_err      <= 1'b0;
         i_data_out <= '0;
         d_data_out <= '0;
`ifdef MEM_ARB_FAIRNESS_EN
         last_id    <= ID_I;
`endif
      end else begin
         // Strobes and pulses default low; they are set only on the entering transition.
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
         i_done <= 1'b0;
         d_done <= 1'b0;
         i_err  <= 1'b0;
         d_err  <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  grant_id <= win_d ? ID_D : ID_I;
                  if (bad_op) begin
                     d_err <= 1'b1;
                     state <= ST_ERR;
                  end else begin
                     hold_addr <= win_d ? d_addr : i_addr;
                     hold_data <= win_d ? d_data_in : 16'h0000;
                     hold_wr   <= win_d & d_wr;
                     mem_wr    <= win_d & d_wr;
                     mem_rd    <= ~(win_d & d_wr);
                     state     <= ST_ISSUE;
                  end
               end
            end

            ST_ISSUE, ST_WAIT: begin
               if (mem_done) begin
                  if (grant_id == ID_D) begin
                     d_done <= 1'b1;
                     // Writes return nothing meaningful, so data_out keeps its last read.
                     if (!hold_wr) d_data_out <= mem_data_out;
                  end else begin
                     i_done <= 1'b1;
                     if (!hold_wr) i_data_out <= mem_data_out;
                  end
                  state <= ST_RESP;
               end else if ((state == ST_WAIT) && tmo_expired) begin
                  if (grant_id == ID_D) d_err <= 1'b1;
                  else                  i_err <= 1'b1;
                  state <= ST_ERR;
               end else begin
                  state <= ST_WAIT;
               end
            end

            ST_RESP, ST_ERR: begin
`ifdef MEM_ARB_FAIRNESS_EN
               last_id <= grant_id;
`endif
               state <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs change and outputs are sampled at the falling clock edge.
// Each comparison goes through chk.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic [15:0] i_addr;
   logic        i_rd;
   logic [15:0] d_addr;
   logic [15:0] d_data_in;
   logic        d_rd;
   logic        d_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_in;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_data_out;
   logic        mem_done;
   logic [15:0] i_data_out;
   logic [15:0] d_data_out;
   logic        i_done;
   logic        d_done;
   logic        i_stall;
   logic        d_stall;
   logic        i_err;
   logic        d_err;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.TIMEOUT_CYCLES(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_addr       (i_addr),
      .i_rd         (i_rd),
      .d_addr       (d_addr),
      .d_data_in    (d_data_in),
      .d_rd         (d_rd),
      .d_wr         (d_wr),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_data_out (mem_data_out),
      .mem_done     (mem_done),
      .i_data_out   (i_data_out),
      .d_data_out   (d_data_out),
      .i_done       (i_done),
      .d_done       (d_done),
      .i_stall      (i_stall),
      .d_stall      (d_stall),
      .i_err        (i_err),
      .d_err        (d_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   int          n;
   logic        hit;
   logic        seen;
   int          gcnt;
   logic [3:0]  seq;

   initial begin
      rst = 1'b0; i_addr = '0; i_rd = 1'b1; d_addr = '0; d_data_in = '0;
      d_rd = 1'b1; d_wr = 1'b0; mem_data_out = '0; mem_done = 1'b0;

      // Reset state, with requests present to show stall is held low.
      step();
      chk("rst_mem_rd",  mem_rd, 0);
      chk("rst_mem_wr",  mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_stall",   {i_stall, d_stall}, 0);
      chk("rst_pulses",  {i_done, d_done, i_err, d_err}, 0);
      chk("rst_data",    {i_data_out, d_data_out}, 0);
      i_rd = 1'b0; d_rd = 1'b0;
      step();
      rst = 1'b1;
      step();

      // d read, memory answers in ISSUE: done two cycles after the request.
      d_addr = 16'h0040; d_rd = 1'b1;
      step();
      chk("t1_mem_rd",   mem_rd, 1);
      chk("t1_mem_wr",   mem_wr, 0);
      chk("t1_mem_addr", mem_addr, 16'h0040);
      chk("t1_d_stall",  d_stall, 1);
      mem_done = 1'b1; mem_data_out = 16'hBEEF;
      step();
      chk("t1_d_done",   d_done, 1);
      chk("t1_i_done",   i_done, 0);
      chk("t1_d_data",   d_data_out, 16'hBEEF);
      chk("t1_strobe_off", mem_rd, 0);
      chk("t1_d_stall_done", d_stall, 0);
      d_rd = 1'b0; mem_done = 1'b0; mem_data_out = 16'h0000;
      step();
      chk("t1_done_one_cycle", d_done, 0);
      chk("t1_data_hold", d_data_out, 16'hBEEF);
      // Stray mem_done while idle must do nothing.
      mem_done = 1'b1; mem_data_out = 16'h3333;
      step();
      step();
      chk("t1_idle_memdone", {i_done, d_done, mem_rd, mem_wr}, 0);
      chk("t1_idle_data", d_data_out, 16'hBEEF);
      mem_done = 1'b0;
      step();

      // i read and d write together, fixed priority: d first, i stalls throughout.
      i_addr = 16'h1234; i_rd = 1'b1;
      d_addr = 16'h2000; d_data_in = 16'h5A5A; d_wr = 1'b1;
      step();
      chk("t2_mem_wr",   mem_wr, 1);
      chk("t2_mem_rd",   mem_rd, 0);
      chk("t2_mem_addr", mem_addr, 16'h2000);
      chk("t2_mem_din",  mem_data_in, 16'h5A5A);
      chk("t2_i_stall_a", i_stall, 1);
      step();
      chk("t2_wait_strobe", mem_wr, 0);
      chk("t2_wait_addr", mem_addr, 16'h2000);
      chk("t2_i_stall_b", i_stall, 1);
      mem_done = 1'b1;
      step();
      chk("t2_d_done",   d_done, 1);
      chk("t2_i_done_0", i_done, 0);
      chk("t2_i_stall_c", i_stall, 1);
      d_wr = 1'b0; mem_done = 1'b0;
      step();
      chk("t2_i_stall_d", i_stall, 1);
      step();
      chk("t2_i_mem_rd", mem_rd, 1);
      chk("t2_i_addr",   mem_addr, 16'h1234);
      chk("t2_i_stall_e", i_stall, 1);
      mem_done = 1'b1; mem_data_out = 16'h7777;
      step();
      chk("t2_i_done",   i_done, 1);
      chk("t2_i_data",   i_data_out, 16'h7777);
      chk("t2_i_stall_f", i_stall, 0);
      i_rd = 1'b0; mem_done = 1'b0;
      step();

      // Memory never answers: abort after 64 WAIT cycles.
      d_addr = 16'h0100; d_rd = 1'b1;
      step();
      chk("t3_mem_rd", mem_rd, 1);
      n = 0; hit = 1'b0; seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         step();
         seen = seen | d_done;
         if (d_err) begin
            hit = 1'b1;
            break;
         end
         n++;
      end
      chk("t3_err_seen",    hit, 1);
      chk("t3_wait_cycles", n, 64);
      chk("t3_no_done",     seen, 0);
      d_rd = 1'b0;
      step();
      chk("t3_err_one_cycle", d_err, 0);
      d_addr = 16'h0200; d_rd = 1'b1;
      step();
      chk("t3_regrant_rd",   mem_rd, 1);
      chk("t3_regrant_addr", mem_addr, 16'h0200);
      mem_done = 1'b1; mem_data_out = 16'h1111;
      step();
      chk("t3_regrant_done", d_done, 1);
      chk("t3_regrant_data", d_data_out, 16'h1111);
      d_rd = 1'b0; mem_done = 1'b0;
      step();

      // Read and write together on the data port: error, never forwarded.
      d_addr = 16'h0400; d_rd = 1'b1; d_wr = 1'b1;
      seen = 1'b0;
      step();
      seen = seen | mem_rd | mem_wr;
      chk("t4_d_err", d_err, 1);
      chk("t4_d_done", d_done, 0);
      d_rd = 1'b0; d_wr = 1'b0;
      step();
      seen = seen | mem_rd | mem_wr;
      chk("t4_err_one_cycle", d_err, 0);
      step();
      seen = seen | mem_rd | mem_wr;
      chk("t4_no_strobe", seen, 0);

      // Reset asserted while waiting on memory.
      d_addr = 16'h0300; d_rd = 1'b1;
      step();
      step();
      chk("t5_in_wait", {mem_rd, d_stall}, 2'b01);
      rst = 1'b0;
      #1;
      chk("t5_rst_addr",   mem_addr, 0);
      chk("t5_rst_outs",   {mem_rd, mem_wr, i_done, d_done, i_err, d_err, i_stall, d_stall}, 0);
      mem_done = 1'b1;
      step();
      step();
      d_rd = 1'b0; mem_done = 1'b0; rst = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         seen = seen | d_done | i_done | d_err | i_err | mem_rd;
      end
      chk("t5_no_pulse_after", seen, 0);

      // Both ports requesting continuously.
      i_addr = 16'hC000; i_rd = 1'b1;
      d_addr = 16'hD000; d_rd = 1'b1;
      gcnt = 0; seq = 4'b0000;
      for (int k = 0; k < 40; k++) begin
         if (gcnt >= 4) break;
         step();
         if (mem_rd) begin
            seq = {seq[2:0], (mem_addr == 16'hD000)};
            gcnt++;
            mem_done = 1'b1;
         end else begin
            mem_done = 1'b0;
         end
      end
      chk("t6_grant_count", gcnt, 4);
`ifdef MEM_ARB_FAIRNESS_EN
      chk("t6_grant_order", seq, 4'b1010);
`else
      chk("t6_grant_order", seq, 4'b1111);
`endif
      i_rd = 1'b0; d_rd = 1'b0;
      step();
      mem_done = 1'b0;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
